// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU pipeline stage registers: default widths,
// the "operand not used" Tuse code and the hazard-metadata record.
package pipe_pkg;

  localparam int unsigned DATA_W = 256;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned TNEW_W = 4;
  localparam int unsigned TUSE_W = 4;

  localparam logic [TUSE_W-1:0] TUSE_NONE = TUSE_W'(4);

  // Hazard metadata travelling alongside the opaque payload
  typedef struct packed {
    logic [ADDR_W-1:0] dst_addr;
    logic [TNEW_W-1:0] tnew;
    logic [TUSE_W-1:0] rs_use;
    logic [TUSE_W-1:0] rt_use;
  } meta_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid buffer for pipe_stage_reg: holds payload plus hazard
// metadata while the main register is stalled, and ages Tnew in place.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = pipe_pkg::DATA_W,
  parameter int unsigned       ADDR_W    = pipe_pkg::ADDR_W,
  parameter int unsigned       TNEW_W    = pipe_pkg::TNEW_W,
  parameter int unsigned       TUSE_W    = pipe_pkg::TUSE_W,
  parameter logic [TUSE_W-1:0] TUSE_NONE = TUSE_W'(pipe_pkg::TUSE_NONE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              pop_i,
  input  logic              age_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] dst_i,
  input  logic [TNEW_W-1:0] tnew_i,
  input  logic [TUSE_W-1:0] rs_use_i,
  input  logic [TUSE_W-1:0] rt_use_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] dst_o,
  output logic [TNEW_W-1:0] tnew_o,
  output logic [TUSE_W-1:0] rs_use_o,
  output logic [TUSE_W-1:0] rt_use_o
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [TNEW_W-1:0] tnew_q, tnew_d;
  logic [TUSE_W-1:0] rs_q, rs_d;
  logic [TUSE_W-1:0] rt_q, rt_d;

  // Entry state register
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      dst_q   <= '0;
      tnew_q  <= '0;
      rs_q    <= TUSE_NONE;
      rt_q    <= TUSE_NONE;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      dst_q   <= dst_d;
      tnew_q  <= tnew_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
    end
  end

  // Next state: clear > load > pop; a held entry keeps counting Tnew down
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    dst_d   = dst_q;
    tnew_d  = (age_i && valid_q && (tnew_q != '0)) ? tnew_q - TNEW_W'(1) : tnew_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      dst_d   = dst_i;
      tnew_d  = tnew_i;
      rs_d    = rs_use_i;
      rt_d    = rt_use_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  assign valid_o  = valid_q;
  assign data_o   = data_q;
  assign dst_o    = dst_q;
  assign tnew_o   = tnew_q;
  assign rs_use_o = rs_q;
  assign rt_use_o = rt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register (D/E, E/M, M/W): payload plus hazard metadata with
// valid/ready handshake, synchronous flush, Tnew ageing while stalled and
// bubble gating of the metadata outputs.
// Build option: define PIPE_SKID_EN to insert a one-entry skid buffer and
// register in_ready (breaks the out_ready -> in_ready path).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = pipe_pkg::DATA_W,
  parameter int unsigned       ADDR_W    = pipe_pkg::ADDR_W,
  parameter int unsigned       TNEW_W    = pipe_pkg::TNEW_W,
  parameter int unsigned       TUSE_W    = pipe_pkg::TUSE_W,
  parameter logic [TUSE_W-1:0] TUSE_NONE = TUSE_W'(pipe_pkg::TUSE_NONE)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_dst_addr,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic [TUSE_W-1:0] in_rs_use,
  input  logic [TUSE_W-1:0] in_rt_use,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_dst_addr,
  output logic [TNEW_W-1:0] out_tnew,
  output logic [TUSE_W-1:0] out_rs_use,
  output logic [TUSE_W-1:0] out_rt_use,
  output logic              out_fwd_ok
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [TNEW_W-1:0] tnew_q, tnew_d;
  logic [TUSE_W-1:0] rs_q, rs_d;
  logic [TUSE_W-1:0] rt_q, rt_d;

  logic accept;
  logic emit;
  logic held;
  logic [TNEW_W-1:0] tnew_aged;

  assign accept    = in_valid && in_ready;
  assign emit      = valid_q && out_ready;
  assign held      = valid_q && !out_ready;
  assign tnew_aged = (tnew_q != '0) ? tnew_q - TNEW_W'(1) : tnew_q;

  // Main register
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      dst_q   <= '0;
      tnew_q  <= '0;
      rs_q    <= TUSE_NONE;
      rt_q    <= TUSE_NONE;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      dst_q   <= dst_d;
      tnew_q  <= tnew_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
    end
  end

`ifdef PIPE_SKID_EN

  logic              skid_valid;
  logic              skid_load;
  logic [DATA_W-1:0] skid_data;
  logic [ADDR_W-1:0] skid_dst;
  logic [TNEW_W-1:0] skid_tnew;
  logic [TUSE_W-1:0] skid_rs;
  logic [TUSE_W-1:0] skid_rt;

  // in_ready comes straight from the registered skid state
  assign in_ready  = !skid_valid;
  assign skid_load = accept && held && !flush;

  pipe_skid_buf #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .TNEW_W    (TNEW_W),
    .TUSE_W    (TUSE_W),
    .TUSE_NONE (TUSE_NONE)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (flush),
    .load_i   (skid_load),
    .pop_i    (emit),
    .age_i    (held),
    .data_i   (in_data),
    .dst_i    (in_dst_addr),
    .tnew_i   (in_tnew),
    .rs_use_i (in_rs_use),
    .rt_use_i (in_rt_use),
    .valid_o  (skid_valid),
    .data_o   (skid_data),
    .dst_o    (skid_dst),
    .tnew_o   (skid_tnew),
    .rs_use_o (skid_rs),
    .rt_use_o (skid_rt)
  );

  // Next state: flush > refill from skid > load input > drain; age while held
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    dst_d   = dst_q;
    tnew_d  = held ? tnew_aged : tnew_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (emit && skid_valid) begin
      valid_d = 1'b1;
      data_d  = skid_data;
      dst_d   = skid_dst;
      tnew_d  = skid_tnew;
      rs_d    = skid_rs;
      rt_d    = skid_rt;
    end else if (accept && !held) begin
      valid_d = 1'b1;
      data_d  = in_data;
      dst_d   = in_dst_addr;
      tnew_d  = in_tnew;
      rs_d    = in_rs_use;
      rt_d    = in_rt_use;
    end else if (emit) begin
      valid_d = 1'b0;
    end
  end

`else

  // Ready whenever the register is empty or draining this cycle
  assign in_ready = !valid_q || out_ready;

  // Next state: flush > load > drain; age while held
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    dst_d   = dst_q;
    tnew_d  = held ? tnew_aged : tnew_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      data_d  = in_data;
      dst_d   = in_dst_addr;
      tnew_d  = in_tnew;
      rs_d    = in_rs_use;
      rt_d    = in_rt_use;
    end else if (emit) begin
      valid_d = 1'b0;
    end
  end

`endif

  // Downstream view: metadata forced to bubble values when empty
  assign out_valid    = valid_q;
  assign out_data     = data_q;
  assign out_dst_addr = valid_q ? dst_q : '0;
  assign out_tnew     = valid_q ? tnew_aged : '0;
  assign out_rs_use   = valid_q ? rs_q : TUSE_NONE;
  assign out_rt_use   = valid_q ? rt_q : TUSE_NONE;
  assign out_fwd_ok   = valid_q && (dst_q != '0) && (tnew_aged == '0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg: a vector table for the streaming
// cases plus hand-written stall, flush, reset and skid sequences.
`timescale 1ns/1ps
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_EN
  localparam logic SKID = 1'b1;
`else
  localparam logic SKID = 1'b0;
`endif

  localparam logic [255:0] DA = {8{32'h0A0A_0001}};
  localparam logic [255:0] DB = {8{32'h0B0B_0002}};
  localparam logic [255:0] DC = {8{32'h0C0C_0003}};
  localparam logic [255:0] DD = {8{32'h0D0D_0004}};
  localparam logic [255:0] DE = {8{32'h0E0E_0005}};
  localparam logic [255:0] DF = {8{32'h0F0F_0006}};
  localparam logic [255:0] DG = {8{32'h1111_0007}};
  localparam logic [255:0] DH = {8{32'h2222_0008}};

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, in_ready, out_valid, out_ready, out_fwd_ok;
  logic [255:0] in_data, out_data;
  logic [4:0]   in_dst_addr, out_dst_addr;
  logic [3:0]   in_tnew, out_tnew, in_rs_use, in_rt_use, out_rs_use, out_rt_use;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic         iv, ordy, fl;
    logic [4:0]   dst;
    logic [3:0]   tnew, rs, rt;
    logic [255:0] data;
    logic         e_valid, e_irdy;
    logic [4:0]   e_dst;
    logic [3:0]   e_tnew, e_rs, e_rt;
    logic         e_fwd;
    logic [255:0] e_data;
  } vec_t;

  vec_t vecs[13];

  pipe_stage_reg dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_dst_addr  (in_dst_addr),
    .in_tnew      (in_tnew),
    .in_rs_use    (in_rs_use),
    .in_rt_use    (in_rt_use),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_dst_addr (out_dst_addr),
    .out_tnew     (out_tnew),
    .out_rs_use   (out_rs_use),
    .out_rt_use   (out_rt_use),
    .out_fwd_ok   (out_fwd_ok)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic iv, input logic ordy, input logic fl,
                              input logic [4:0] dst, input logic [3:0] tnew,
                              input logic [3:0] rs, input logic [3:0] rt,
                              input logic [255:0] data,
                              input logic ev, input logic eir, input logic [4:0] edst,
                              input logic [3:0] etnew, input logic [3:0] ers,
                              input logic [3:0] ert, input logic efwd,
                              input logic [255:0] edata);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.dst = dst; v.tnew = tnew;
    v.rs = rs; v.rt = rt; v.data = data;
    v.e_valid = ev; v.e_irdy = eir; v.e_dst = edst; v.e_tnew = etnew;
    v.e_rs = ers; v.e_rt = ert; v.e_fwd = efwd; v.e_data = edata;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic ordy, input logic fl,
                       input logic [4:0] dst, input logic [3:0] tnew,
                       input logic [3:0] rs, input logic [3:0] rt,
                       input logic [255:0] data);
    in_valid    = iv;
    out_ready   = ordy;
    flush       = fl;
    in_dst_addr = dst;
    in_tnew     = tnew;
    in_rs_use   = rs;
    in_rt_use   = rt;
    in_data     = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string nm);
    chk({nm, "_valid"}, out_valid, 1'b0);
    chk({nm, "_dst"}, out_dst_addr, 5'd0);
    chk({nm, "_tnew"}, out_tnew, 4'd0);
    chk({nm, "_rs"}, out_rs_use, 4'd4);
    chk({nm, "_rt"}, out_rt_use, 4'd4);
    chk({nm, "_fwd"}, out_fwd_ok, 1'b0);
  endtask

  initial begin
    // Streaming table: expectations are the outputs seen before the edge
    vecs[0]  = mk(1'b0, 1'b1, 1'b0, 5'd0, 4'd0,  4'd0, 4'd0, '0, 1'b0, 1'b1, 5'd0, 4'd0,  4'd4, 4'd4, 1'b0, '0);
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 5'd5, 4'd2,  4'd1, 4'd2, DA, 1'b0, 1'b1, 5'd0, 4'd0,  4'd4, 4'd4, 1'b0, '0);
    vecs[2]  = mk(1'b0, 1'b1, 1'b0, 5'd0, 4'd0,  4'd0, 4'd0, '0, 1'b1, 1'b1, 5'd5, 4'd1,  4'd1, 4'd2, 1'b0, DA);
    vecs[3]  = mk(1'b0, 1'b1, 1'b0, 5'd0, 4'd0,  4'd0, 4'd0, '0, 1'b0, 1'b1, 5'd0, 4'd0,  4'd4, 4'd4, 1'b0, '0);
    vecs[4]  = mk(1'b1, 1'b1, 1'b0, 5'd7, 4'd1,  4'd0, 4'd4, DB, 1'b0, 1'b1, 5'd0, 4'd0,  4'd4, 4'd4, 1'b0, '0);
    vecs[5]  = mk(1'b1, 1'b1, 1'b0, 5'd0, 4'd0,  4'd3, 4'd3, DC, 1'b1, 1'b1, 5'd7, 4'd0,  4'd0, 4'd4, 1'b1, DB);
    vecs[6]  = mk(1'b0, 1'b1, 1'b0, 5'd0, 4'd0,  4'd0, 4'd0, '0, 1'b1, 1'b1, 5'd0, 4'd0,  4'd3, 4'd3, 1'b0, DC);
    vecs[7]  = mk(1'b0, 1'b0, 1'b0, 5'd0, 4'd0,  4'd0, 4'd0, '0, 1'b0, 1'b1, 5'd0, 4'd0,  4'd4, 4'd4, 1'b0, '0);
    vecs[8]  = mk(1'b1, 1'b1, 1'b1, 5'd3, 4'd0,  4'd2, 4'd2, DD, 1'b0, 1'b1, 5'd0, 4'd0,  4'd4, 4'd4, 1'b0, '0);
    vecs[9]  = mk(1'b0, 1'b1, 1'b0, 5'd0, 4'd0,  4'd0, 4'd0, '0, 1'b0, 1'b1, 5'd0, 4'd0,  4'd4, 4'd4, 1'b0, '0);
    vecs[10] = mk(1'b1, 1'b1, 1'b0, 5'd4, 4'd15, 4'd1, 4'd1, DE, 1'b0, 1'b1, 5'd0, 4'd0,  4'd4, 4'd4, 1'b0, '0);
    vecs[11] = mk(1'b0, 1'b1, 1'b0, 5'd0, 4'd0,  4'd0, 4'd0, '0, 1'b1, 1'b1, 5'd4, 4'd14, 4'd1, 4'd1, 1'b0, DE);
    vecs[12] = mk(1'b0, 1'b1, 1'b0, 5'd0, 4'd0,  4'd0, 4'd0, '0, 1'b0, 1'b1, 5'd0, 4'd0,  4'd4, 4'd4, 1'b0, '0);

    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 4'd0, 4'd0, '0);
    step();
    step();
    reset = 1'b0;
    #1;

    // Reset state, no input
    chk_bubble("reset");
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_data", out_data, 256'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].ordy, vecs[i].fl, vecs[i].dst, vecs[i].tnew,
            vecs[i].rs, vecs[i].rt, vecs[i].data);
      #1;
      chk($sformatf("v%0d_valid", i), out_valid, vecs[i].e_valid);
      chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_irdy);
      chk($sformatf("v%0d_dst", i), out_dst_addr, vecs[i].e_dst);
      chk($sformatf("v%0d_tnew", i), out_tnew, vecs[i].e_tnew);
      chk($sformatf("v%0d_rs", i), out_rs_use, vecs[i].e_rs);
      chk($sformatf("v%0d_rt", i), out_rt_use, vecs[i].e_rt);
      chk($sformatf("v%0d_fwd", i), out_fwd_ok, vecs[i].e_fwd);
      if (vecs[i].e_valid)
        chk($sformatf("v%0d_data", i), out_data, vecs[i].e_data);
      step();
    end

    // Stall with tnew=3: out_tnew 2,1,0,0, payload stable
    drive(1'b1, 1'b0, 1'b0, 5'd9, 4'd3, 4'd2, 4'd4, DF);
    #1;
    chk("hold_accept_ready", in_ready, 1'b1);
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 4'd0, 4'd0, '0);
    #1;
    chk("hold0_valid", out_valid, 1'b1);
    chk("hold0_tnew", out_tnew, 4'd2);
    chk("hold0_fwd", out_fwd_ok, 1'b0);
    chk("hold0_in_ready", in_ready, SKID);
    step();
    chk("hold1_tnew", out_tnew, 4'd1);
    chk("hold1_fwd", out_fwd_ok, 1'b0);
    step();
    chk("hold2_tnew", out_tnew, 4'd0);
    chk("hold2_fwd", out_fwd_ok, 1'b1);
    step();
    chk("hold3_tnew", out_tnew, 4'd0);
    chk("hold3_fwd", out_fwd_ok, 1'b1);
    chk("hold3_dst", out_dst_addr, 5'd9);
    chk("hold3_data", out_data, DF);
    chk("hold3_rs", out_rs_use, 4'd2);

    // out_ready -> in_ready path
    out_ready = 1'b1;
    #1;
    chk("comb_ready_up", in_ready, 1'b1);
    out_ready = 1'b0;
    #1;
    chk("comb_ready_down", in_ready, SKID);

    // Flush while held with a new entry offered
    drive(1'b1, 1'b0, 1'b1, 5'd11, 4'd0, 4'd1, 4'd1, DG);
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 4'd0, 4'd0, '0);
    #1;
    chk_bubble("flush");
    chk("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    step();
    chk("flush_lost_valid", out_valid, 1'b0);

    // Reset in the middle of a stall drops the held entry
    drive(1'b1, 1'b0, 1'b0, 5'd6, 4'd2, 4'd1, 4'd1, DH);
    step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 4'd0, 4'd0, '0);
    #1;
    chk("rst_stall_pre_valid", out_valid, 1'b1);
    chk("rst_stall_pre_dst", out_dst_addr, 5'd6);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk_bubble("rst_stall");
    chk("rst_stall_in_ready", in_ready, 1'b1);
    chk("rst_stall_data", out_data, 256'd0);
    out_ready = 1'b1;
    step();
    chk("rst_stall_after_valid", out_valid, 1'b0);

`ifdef PIPE_SKID_EN
    // Skid ordering: A in main, B into skid, C waits; then drain A,B,C
    drive(1'b1, 1'b1, 1'b0, 5'd1, 4'd1, 4'd1, 4'd1, DA);
    #1;
    chk("skid_a_ready", in_ready, 1'b1);
    step();
    drive(1'b1, 1'b0, 1'b0, 5'd2, 4'd3, 4'd1, 4'd1, DB);
    #1;
    chk("skid_b_ready", in_ready, 1'b1);
    chk("skid_a_data0", out_data, DA);
    step();
    drive(1'b1, 1'b0, 1'b0, 5'd3, 4'd0, 4'd1, 4'd1, DC);
    #1;
    chk("skid_full_ready", in_ready, 1'b0);
    chk("skid_a_data1", out_data, DA);
    step();
    chk("skid_a_data2", out_data, DA);
    chk("skid_a_tnew", out_tnew, 4'd0);
    out_ready = 1'b1;
    #1;
    chk("skid_no_comb_ready", in_ready, 1'b0);
    step();
    chk("skid_b_valid", out_valid, 1'b1);
    chk("skid_b_data", out_data, DB);
    chk("skid_b_dst", out_dst_addr, 5'd2);
    chk("skid_b_tnew", out_tnew, 4'd1);
    chk("skid_b_ready", in_ready, 1'b1);
    step();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 4'd0, 4'd0, 4'd0, '0);
    #1;
    chk("skid_c_valid", out_valid, 1'b1);
    chk("skid_c_data", out_data, DC);
    chk("skid_c_dst", out_dst_addr, 5'd3);
    step();
    chk("skid_end_valid", out_valid, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the five-stage CPU. It carries an opaque payload plus hazard metadata (destination register, Tnew countdown, rs/rt Tuse) between stages. It adds a valid/ready handshake, synchronous flush and Tnew ageing while stalled, and gates metadata on bubbles. It replaces the per-stage hand-written registers between D/E, E/M and M/W.

## Interface
- DATA_W, 256, width of the opaque payload (PC, operands, control fields, HI/LO)
- ADDR_W, 5, register-address width
- TNEW_W, 4, Tnew counter width
- TUSE_W, 4, Tuse field width
- TUSE_NONE, 4, Tuse value meaning "operand not used"
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  discard all held and incoming entries this cycle
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry
- in_data  in  DATA_W  payload
- in_dst_addr  in  ADDR_W  destination register (0 = none)
- in_tnew  in  TNEW_W  cycles until result is available, counted at the input of this stage
- in_rs_use, in_rt_use  in  TUSE_W  Tuse of rs/rt
- out_valid  out  1  entry presented downstream
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  payload
- out_dst_addr  out  ADDR_W  destination, 0 when !out_valid
- out_tnew  out  TNEW_W  stored Tnew minus 1, saturating at 0; 0 when !out_valid
- out_rs_use, out_rt_use  out  TUSE_W  stored Tuse; TUSE_NONE when !out_valid
- out_fwd_ok  out  1  out_valid && out_dst_addr!=0 && out_tnew==0

## Operation
- Accept: in_valid && in_ready. Emit: out_valid && out_ready.
- Base mode: in_ready = !out_valid || out_ready, combinational from out_ready.
- On accept, the main register loads all inputs and sets valid. On emit without accept, valid clears.
- Held cycle (out_valid && !out_ready): stored Tnew decrements, saturating at 0. A multicycle result keeps ageing in place. Payload, dst and Tuse are unchanged.
- Flush: clears main (and skid) valid next edge. A same-cycle accept is discarded. Flush has priority over load. in_ready is unaffected by flush.
- Bubble gating: when !out_valid, out_dst_addr=0, out_tnew=0, Tuse=TUSE_NONE, out_fwd_ok=0. out_data holds the last value and is don't-care.
- Reset: valid=0, dst=0, Tnew=0, Tuse=TUSE_NONE, payload=0. All outputs at their bubble values; in_ready=1 in base mode.
- Width rule: Tnew arithmetic is unsigned TNEW_W. In the decrement, 0 stays 0 and no wrap is allowed.

## Timing
- Latency 1 cycle, in to out, when unstalled. Throughput 1 entry/cycle.
- Base mode has a combinational path out_ready -> in_ready. No other comb paths from inputs to outputs, except the out_* metadata gating on the registered valid.
- Reset and flush take effect at the same edge. Reset overrides flush.
- Asserting reset mid-stall drops the held entry. No emit occurs.

## Configuration
- PIPE_SKID_EN defined: a one-entry skid buffer is inserted. in_ready = !skid_valid, registered, so there is no out_ready -> in_ready path.
  - If an accept occurs while main is held, the entry goes to skid.
  - On the next emit, skid moves into main.
  - Skid Tnew ages on held cycles like main.
  - Flush clears both.
  - Order is preserved.
  - Reset: skid_valid=0.
- Undefined: base mode with no skid storage. in_ready follows the formula in Operation.

## Structure
- Shared package pipe_pkg holds:
  - default widths (ADDR_W, TNEW_W, TUSE_W)
  - the TUSE_NONE constant
  - a packed struct for metadata (dst_addr, tnew, rs_use, rt_use)
- Sub-module pipe_skid_buf is one entry: data+metadata, valid, ageing logic. It is instantiated only under PIPE_SKID_EN.

## Test plan
- Reset, then no input: out_valid=0, in_ready=1, out_rs_use=4, out_tnew=0, out_fwd_ok=0.
- Accept dst=5, tnew=2, out_ready=1: next cycle out_dst_addr=5, out_tnew=1, out_fwd_ok=0. Entry leaves the following cycle.
- Accept tnew=3, hold out_ready=0 for 3 cycles: out_tnew reads 2,1,0,0. out_fwd_ok rises on the third cycle. Payload is stable.
- Held entry plus flush with in_valid=1: next cycle out_valid=0, the new entry is lost, and metadata shows bubble values.
- Base mode, out_valid=1, out_ready=0: in_ready=0 in the same cycle. Raising out_ready raises in_ready combinationally.
- PIPE_SKID_EN, stream A,B,C with out_ready=0 after A: B enters skid and in_ready=0. Release out_ready: outputs A,B,C in order with no loss or duplication.
